// File: rtl/pipeline_fwd_scoreboard.sv
// In-flight register-write scoreboard with multi-port operand forwarding and load-use stall.
// Optional macro FWD_LATE_BYPASS_EN forwards returning load data in the cycle it arrives.
module pipeline_fwd_scoreboard_lane #(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 5,
  parameter int FWD_DEPTH = 3
) (
  input  logic [IDX_W-1:0]                  idx,
  input  logic [DATA_W-1:0]                 rf_val,
  input  logic [FWD_DEPTH-1:0]              sb_vld,
  input  logic [FWD_DEPTH-1:0]              sb_rdy,
  input  logic [FWD_DEPTH-1:0][IDX_W-1:0]   sb_idx,
  input  logic [FWD_DEPTH-1:0][DATA_W-1:0]  sb_val,
  input  logic [FWD_DEPTH-1:0]              byp_slot,
  input  logic [DATA_W-1:0]                 byp_data,
  output logic [DATA_W-1:0]                 fwd,
  output logic                              stall
);
  logic              hit, hit_rdy, hit_byp;
  logic [DATA_W-1:0] hit_val;

  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_byp = 1'b0;
    hit_val = '0;
    // Scan oldest to youngest so the youngest match wins, ready or not.
    for (int k = FWD_DEPTH-1; k >= 0; k--) begin
      if (sb_vld[k] && sb_idx[k] == idx) begin
        hit     = 1'b1;
        hit_rdy = sb_rdy[k];
        hit_byp = byp_slot[k];
        hit_val = sb_val[k];
      end
    end
    fwd   = rf_val;
    stall = 1'b0;
    if (idx == '0) begin
      fwd = '0;
    end else if (hit) begin
      if (hit_rdy)      fwd = hit_val;
      else if (hit_byp) fwd = byp_data;
      else begin
        fwd   = hit_val;
        stall = 1'b1;
      end
    end
  end
endmodule

module pipeline_fwd_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 5,
  parameter int READ_PORTS = 2,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [READ_PORTS*IDX_W-1:0]  src_idx,
  input  logic [READ_PORTS*DATA_W-1:0] src_rf_val,
  output logic [READ_PORTS*DATA_W-1:0] fwd_val,
  input  logic                         issue_valid,
  input  logic                         issue_we,
  input  logic [IDX_W-1:0]             issue_rd,
  input  logic                         issue_is_load,
  input  logic [DATA_W-1:0]            issue_result,
  input  logic                         flush,
  input  logic                         load_data_valid,
  input  logic [DATA_W-1:0]            load_data,
  output logic                         stall_out,
  output logic [15:0]                  stall_count,
  output logic                         proto_err
);
  if (LOAD_LAT < 1 || FWD_DEPTH < LOAD_LAT + 1) begin : g_bad_cfg
    $error("pipeline_fwd_scoreboard: need LOAD_LAT >= 1 and FWD_DEPTH >= LOAD_LAT+1");
  end

  logic [FWD_DEPTH-1:0]             vld_pipe;
  logic [FWD_DEPTH-1:0]             sb_rdy;
  logic [FWD_DEPTH-1:0][IDX_W-1:0]  sb_idx;
  logic [FWD_DEPTH-1:0][DATA_W-1:0] sb_val;
  logic [FWD_DEPTH-1:0]             byp_slot;
  logic [DATA_W-1:0]                byp_data;
  logic [READ_PORTS-1:0]            port_stall;
  logic                             accept, ld_hit;

  assign accept    = issue_valid & ~stall_out & ~flush;
  assign ld_hit    = load_data_valid & vld_pipe[LOAD_LAT-1] & ~sb_rdy[LOAD_LAT-1];
  assign stall_out = |port_stall;

  // Bypass mask is constant zero unless the late bypass is built in.
  always_comb begin
    byp_slot = '0;
    byp_data = '0;
`ifdef FWD_LATE_BYPASS_EN
    byp_slot[LOAD_LAT-1] = ld_hit;
    byp_data             = load_data;
`endif
  end

  pipeline_fwd_scoreboard_lane #(
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W),
    .FWD_DEPTH (FWD_DEPTH)
  ) u_lane [READ_PORTS-1:0] (
    .idx      (src_idx),
    .rf_val   (src_rf_val),
    .sb_vld   (vld_pipe),
    .sb_rdy   (sb_rdy),
    .sb_idx   (sb_idx),
    .sb_val   (sb_val),
    .byp_slot (byp_slot),
    .byp_data (byp_data),
    .fwd      (fwd_val),
    .stall    (port_stall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe    <= '0;
      sb_rdy      <= '0;
      sb_idx      <= '0;
      sb_val      <= '0;
      stall_count <= '0;
      proto_err   <= 1'b0;
    end else begin
      for (int k = FWD_DEPTH-1; k > 0; k--) begin
        vld_pipe[k] <= vld_pipe[k-1];
        sb_rdy[k]   <= sb_rdy[k-1];
        sb_idx[k]   <= sb_idx[k-1];
        sb_val[k]   <= sb_val[k-1];
      end
      vld_pipe[0] <= accept & issue_we & (issue_rd != '0);
      sb_idx[0]   <= issue_rd;
      sb_rdy[0]   <= ~issue_is_load;
      sb_val[0]   <= issue_result;
      // Returning load data lands in the slot the pending load shifts into.
      if (ld_hit) begin
        sb_rdy[LOAD_LAT] <= 1'b1;
        sb_val[LOAD_LAT] <= load_data;
      end
      if (load_data_valid && !ld_hit)
        proto_err <= 1'b1;
      if (stall_out && issue_valid && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_fwd_scoreboard.sv
// Scoreboard-driven bench for pipeline_fwd_scoreboard (default parameters).
module tb_pipeline_fwd_scoreboard;
  localparam int DW = 32, IW = 5, RP = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [RP*IW-1:0]    src_idx;
  logic [RP*DW-1:0]    src_rf_val;
  logic [RP*DW-1:0]    fwd_val;
  logic                issue_valid, issue_we, issue_is_load, flush;
  logic [IW-1:0]       issue_rd;
  logic [DW-1:0]       issue_result, load_data;
  logic                load_data_valid;
  logic                stall_out, proto_err;
  logic [15:0]         stall_count;

  pipeline_fwd_scoreboard dut (
    .clk(clk), .rst(rst), .src_idx(src_idx), .src_rf_val(src_rf_val), .fwd_val(fwd_val),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .issue_result(issue_result), .flush(flush),
    .load_data_valid(load_data_valid), .load_data(load_data),
    .stall_out(stall_out), .stall_count(stall_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef enum int { K_FWD0, K_FWD1, K_STALL, K_CNT, K_PERR } kind_e;
  typedef struct { string tag; kind_e kind; logic [31:0] exp; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0;

`ifdef FWD_LATE_BYPASS_EN
  localparam logic [31:0] LU_STALL = 32'd0, LU_CNT = 32'd0;
`else
  localparam logic [31:0] LU_STALL = 32'd1, LU_CNT = 32'd1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_v(input string tag, input kind_e kind, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = v;
    exp_q.push_back(e);
  endtask

  // Sample mid-cycle, drain the expectations queued for this cycle, then advance.
  task automatic tick();
    exp_t e;
    logic [31:0] obs;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_FWD0:  obs = fwd_val[31:0];
        K_FWD1:  obs = fwd_val[63:32];
        K_STALL: obs = {31'd0, stall_out};
        K_CNT:   obs = {16'd0, stall_count};
        default: obs = {31'd0, proto_err};
      endcase
      check(e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd_port(input int p, input logic [IW-1:0] idx, input logic [DW-1:0] rf);
    src_idx[p*IW +: IW]    = idx;
    src_rf_val[p*DW +: DW] = rf;
  endtask

  task automatic iss(input logic v, input logic we, input logic ld, input logic fl,
                     input logic [IW-1:0] rd, input logic [DW-1:0] res);
    issue_valid = v; issue_we = we; issue_is_load = ld; flush = fl;
    issue_rd = rd; issue_result = res;
  endtask

  task automatic ldret(input logic v, input logic [DW-1:0] d);
    load_data_valid = v; load_data = d;
  endtask

  initial begin
    rst = 1'b0;
    src_idx = '0; src_rf_val = '0;
    iss(0, 0, 0, 0, 0, 0);
    ldret(0, 0);

    // reset state
    rd_port(0, 5'd5, 32'h11); rd_port(1, 5'd0, 32'h22);
    expect_v("rst_fwd0", K_FWD0, 32'h11);
    expect_v("rst_fwd1", K_FWD1, 32'h0);
    expect_v("rst_stall", K_STALL, 0);
    expect_v("rst_cnt", K_CNT, 0);
    expect_v("rst_perr", K_PERR, 0);
    tick();
    rst = 1'b1;
    rd_port(0, 0, 0); rd_port(1, 0, 0);
    tick();

    // ALU back-to-back, visible for FWD_DEPTH cycles then regfile
    iss(1, 1, 0, 0, 5'd3, 32'hDEAD);
    expect_v("alu_issue_stall", K_STALL, 0);
    tick();
    iss(0, 0, 0, 0, 0, 0);
    rd_port(0, 5'd3, 32'h0);
    for (int i = 0; i < 3; i++) begin
      expect_v("alu_fwd", K_FWD0, 32'hDEAD);
      tick();
    end
    rd_port(0, 5'd3, 32'h1234);
    expect_v("alu_retired_rf", K_FWD0, 32'h1234);
    tick();
    rd_port(0, 0, 0);

    // youngest wins, r0 never forwarded
    iss(1, 1, 0, 0, 5'd4, 32'hA);
    tick();
    iss(1, 1, 0, 0, 5'd4, 32'hB);
    rd_port(1, 5'd4, 32'h77);
    expect_v("yw_first", K_FWD1, 32'hA);
    tick();
    iss(1, 1, 0, 0, 5'd0, 32'h5);
    expect_v("yw_young", K_FWD1, 32'hB);
    tick();
    iss(0, 0, 0, 0, 0, 0);
    rd_port(0, 5'd0, 32'h99);
    expect_v("r0_zero", K_FWD0, 32'h0);
    expect_v("yw_older_slot", K_FWD1, 32'hB);
    tick();
    rd_port(0, 0, 0); rd_port(1, 0, 0);
    tick(); tick(); tick();

    // load-use
    iss(1, 1, 1, 0, 5'd7, 32'hBAD);
    tick();
    iss(1, 1, 0, 0, 5'd8, 32'h1);
    rd_port(0, 5'd7, 32'h55);
    ldret(1, 32'hCAFE);
    expect_v("lu_stall", K_STALL, LU_STALL);
    expect_v("lu_cnt_before", K_CNT, 0);
`ifdef FWD_LATE_BYPASS_EN
    expect_v("lu_late_fwd", K_FWD0, 32'hCAFE);
`endif
    tick();
    ldret(0, 0);
    expect_v("lu_fwd", K_FWD0, 32'hCAFE);
    expect_v("lu_stall_clear", K_STALL, 0);
    expect_v("lu_cnt", K_CNT, LU_CNT);
    tick();

    // flush: no entry created; orphan load data flags proto_err
    rd_port(0, 0, 0);
    iss(1, 1, 0, 1, 5'd9, 32'h9999);
    expect_v("fl_stall", K_STALL, 0);
    tick();
    iss(0, 0, 0, 0, 0, 0);
    rd_port(0, 5'd9, 32'h42);
    ldret(1, 32'h1);
    expect_v("fl_not_fwd", K_FWD0, 32'h42);
    expect_v("perr_pre", K_PERR, 0);
    tick();
    ldret(0, 0);
    rd_port(0, 0, 0);
    expect_v("perr_set", K_PERR, 1);
    tick();
    expect_v("perr_sticky", K_PERR, 1);
    tick();

    // younger pending load hides older ready entry; late load stays pending
    iss(1, 1, 0, 0, 5'd10, 32'hAA);
    tick();
    iss(1, 1, 1, 0, 5'd10, 32'h0);
    rd_port(1, 5'd10, 32'h31);
    expect_v("hide_pre_fwd", K_FWD1, 32'hAA);
    expect_v("hide_pre_stall", K_STALL, 0);
    tick();
    iss(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_v("hide_stall", K_STALL, 1);
      tick();
    end
    expect_v("hide_retired", K_FWD1, 32'h31);
    expect_v("hide_stall_clear", K_STALL, 0);
    expect_v("hide_cnt_no_issue", K_CNT, LU_CNT);
    tick();
    rd_port(1, 0, 0);

    // reset mid-flight drops the pending load
    iss(1, 1, 1, 0, 5'd11, 32'h0);
    tick();
    iss(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    rd_port(0, 5'd11, 32'h66);
    expect_v("mrst_fwd", K_FWD0, 32'h66);
    expect_v("mrst_stall", K_STALL, 0);
    expect_v("mrst_cnt", K_CNT, 0);
    expect_v("mrst_perr", K_PERR, 0);
    tick();
    rst = 1'b1;
    ldret(1, 32'h7);
    expect_v("mrst_perr_pre", K_PERR, 0);
    tick();
    ldret(0, 0);
    expect_v("mrst_perr_late_data", K_PERR, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
